// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port synchronous RAM between the pipeline MEM stage
// and a debug/loader port, with sub-word store lane steering and load extension.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              p_req_i,
    input  logic              p_we_i,
    input  logic [2:0]        p_funct3_i,
    input  logic [31:0]       p_addr_i,
    input  logic [31:0]       p_wdata_i,
    output logic              p_stall_o,
    output logic              p_rvalid_o,
    output logic [31:0]       p_rdata_o,
    output logic              p_err_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StPRd, StDRd} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      funct3_q, funct3_d;

    logic [1:0]  p_off, p_size;
    logic        p_illegal, wait_full, p_win, d_win;
    logic [3:0]  st_be;
    logic [31:0] st_data, ld_shifted, ld_data;
    logic        unused_addr;

    // Upper address bits and the debug byte offset are ignored by design.
    assign unused_addr = ^{p_addr_i, d_addr_i};

    assign p_off  = p_addr_i[1:0];
    assign p_size = p_funct3_i[1:0];

    assign p_illegal = (p_funct3_i == 3'b011) || (p_funct3_i == 3'b110) ||
                       (p_funct3_i == 3'b111) ||
                       ((p_size == 2'b01) && p_off[0]) ||
                       ((p_size == 2'b10) && (p_off != 2'b00));

    assign wait_full = (wait_q == CntW'(MAX_WAIT));
    assign p_win     = (state_q == StIdle) && p_req_i && !wait_full;
    assign d_win     = (state_q == StIdle) && d_req_i && !p_win;

    always_comb begin
        st_be   = 4'b1111;
        st_data = p_wdata_i;
        case (p_size)
            2'b00: begin
                st_be   = 4'b0001 << p_off;
                st_data = {4{p_wdata_i[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << p_off;
                st_data = {2{p_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Offset and size were captured at grant; the RAM word arrives one cycle later.
    assign ld_shifted = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_data = ld_shifted;
        case (funct3_q[1:0])
            2'b00: ld_data = funct3_q[2] ? {24'b0, ld_shifted[7:0]}
                                         : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01: ld_data = funct3_q[2] ? {16'b0, ld_shifted[15:0]}
                                         : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        p_stall_o   = 1'b0;
        p_rvalid_o  = 1'b0;
        p_rdata_o   = 32'b0;
        p_err_o     = 1'b0;
        d_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = 32'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = 32'b0;

        unique case (state_q)
            StIdle: begin
                if (p_win) begin
                    if (p_illegal) begin
                        p_err_o = 1'b1;
                    end else if (p_we_i) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = st_be;
                        mem_addr_o  = p_addr_i[ADDR_W+1:2];
                        mem_wdata_o = st_data;
                    end else begin
                        mem_en_o   = 1'b1;
                        mem_addr_o = p_addr_i[ADDR_W+1:2];
                        p_stall_o  = 1'b1;
                        off_d      = p_off;
                        funct3_d   = p_funct3_i;
                        state_d    = StPRd;
                    end
                end else begin
                    p_stall_o = p_req_i;
                    if (d_win) begin
                        d_gnt_o     = 1'b1;
                        mem_en_o    = 1'b1;
                        mem_we_o    = d_we_i ? 4'b1111 : 4'b0000;
                        mem_addr_o  = d_addr_i[ADDR_W+1:2];
                        mem_wdata_o = d_wdata_i;
                        if (!d_we_i) begin
                            state_d = StDRd;
                        end
                    end
                end
            end
            StPRd: begin
                p_rvalid_o = !flush_i;
                p_rdata_o  = flush_i ? 32'b0 : ld_data;
                state_d    = StIdle;
            end
            StDRd: begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = mem_rdata_i;
                p_stall_o  = p_req_i;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (d_gnt_o) begin
            wait_d = '0;
        end else if (d_req_i && !wait_full) begin
            wait_d = wait_q + 1'b1;
        end

        // Outputs are combinational, so hold them quiet for the whole reset interval.
        if (!rst_ni) begin
            p_stall_o   = 1'b0;
            p_rvalid_o  = 1'b0;
            p_rdata_o   = 32'b0;
            p_err_o     = 1'b0;
            d_gnt_o     = 1'b0;
            d_rvalid_o  = 1'b0;
            d_rdata_o   = 32'b0;
            mem_en_o    = 1'b0;
            mem_we_o    = 4'b0000;
            mem_addr_o  = '0;
            mem_wdata_o = 32'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
        end
    end

endmodule
